// File: rtl/node_mac_array.sv
// node_mac_array: NUM_NODES parallel fixed-point neurons sharing one x stream.
// Each lane accumulates x*w over a pass, then adds its bias, rescales,
// saturates and optionally applies ReLU. One lane result at a time is
// presented on the memory write bus, chosen by data_select_c2node.
module node_mac_array #(
  parameter int DATA_W    = 16,
  parameter int FRAC      = 8,
  parameter int ACC_W     = 40,
  parameter int NUM_NODES = 10,
  parameter int SEL_W     = 4
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          head_c2node,
  input  logic                          rd_en_c2mem,
  input  logic [SEL_W-1:0]              data_select_c2node,
  input  logic                          relu_en,
  input  logic [DATA_W-1:0]             x_data_mem2node,
  input  logic [NUM_NODES*DATA_W-1:0]   w_data_mem2node,
  input  logic [NUM_NODES*DATA_W-1:0]   b_data_mem2node,
  output logic                          done_flag_node2c,
  output logic [DATA_W-1:0]             node_data_node2mem,
  output logic                          busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_CNT = 3'd1,
    S_ACCUM    = 3'd2,
    S_BIAS     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Saturation bounds of a DATA_W-bit signed word, expressed at ACC_W width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                   state_q;
  logic [DATA_W-1:0]        remaining_q;
  logic signed [ACC_W-1:0]  acc_q     [NUM_NODES];
  logic signed [ACC_W-1:0]  acc_d     [NUM_NODES];
  logic [DATA_W-1:0]        result_q  [NUM_NODES];
  logic [DATA_W-1:0]        result_d  [NUM_NODES];
  logic                     done_q;
  logic                     busy_q;
  logic [DATA_W-1:0]        node_data_d;

  // Full-precision signed product x*w, sign-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] mac_term(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] w
  );
    logic signed [2*DATA_W-1:0] x_ext;
    logic signed [2*DATA_W-1:0] w_ext;
    logic signed [2*DATA_W-1:0] prod;
    x_ext    = {{DATA_W{x[DATA_W-1]}}, x};
    w_ext    = {{DATA_W{w[DATA_W-1]}}, w};
    prod     = x_ext * w_ext;
    mac_term = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  endfunction

  // Bias add in the accumulator's Q format, rescale to Q7.8, saturate, ReLU.
  function automatic logic [DATA_W-1:0] convert(
    input logic signed [ACC_W-1:0] acc,
    input logic [DATA_W-1:0]       bias,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    sum      = acc + (bias_ext <<< FRAC);
    shifted  = sum >>> FRAC;
    if (relu && shifted[ACC_W-1]) begin
      convert = {DATA_W{1'b0}};
    end else if (shifted > SAT_MAX) begin
      convert = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      convert = SAT_MIN[DATA_W-1:0];
    end else begin
      convert = shifted[DATA_W-1:0];
    end
  endfunction

  // Per-lane next accumulator value and converted result candidate.
  always_comb begin
    for (int i = 0; i < NUM_NODES; i++) begin
      acc_d[i]    = acc_q[i] + mac_term(x_data_mem2node, w_data_mem2node[i*DATA_W +: DATA_W]);
      result_d[i] = convert(acc_q[i], b_data_mem2node[i*DATA_W +: DATA_W], relu_en);
    end
  end

  // Result read mux; selects beyond the last lane read as zero.
  always_comb begin
    node_data_d = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_NODES; i++) begin
      if (data_select_c2node == SEL_W'(i)) begin
        node_data_d = result_q[i];
      end else begin
        node_data_d = node_data_d;
      end
    end
  end

  // Pass sequencer: head restarts from any state, rd_en gates accumulation.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= {DATA_W{1'b0}};
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) begin
        acc_q[i]    <= {ACC_W{1'b0}};
        result_q[i] <= {DATA_W{1'b0}};
      end
    end else if (head_c2node) begin
      state_q <= S_LOAD_CNT;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      for (int i = 0; i < NUM_NODES; i++) begin
        acc_q[i] <= {ACC_W{1'b0}};
      end
    end else begin
      case (state_q)
        S_LOAD_CNT: begin
          remaining_q <= x_data_mem2node;
          if (x_data_mem2node == {DATA_W{1'b0}}) begin
            state_q <= S_BIAS;
          end else begin
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (rd_en_c2mem) begin
            for (int i = 0; i < NUM_NODES; i++) begin
              acc_q[i] <= acc_d[i];
            end
            remaining_q <= remaining_q - {{(DATA_W-1){1'b0}}, 1'b1};
            if (remaining_q == {{(DATA_W-1){1'b0}}, 1'b1}) begin
              state_q <= S_BIAS;
            end else begin
              state_q <= S_ACCUM;
            end
          end else begin
            state_q <= S_ACCUM;
          end
        end
        S_BIAS: begin
          for (int i = 0; i < NUM_NODES; i++) begin
            result_q[i] <= result_d[i];
          end
          state_q <= S_DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        S_IDLE, S_DONE: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done_flag_node2c   = done_q;
  assign busy               = busy_q;
  assign node_data_node2mem = node_data_d;

endmodule
